// File: rtl/sia_rx_fifo_pkg.sv
// Shared constants for the SIA receive path: captured word width and the RX status
// bit positions that the register block and firmware headers also use.
package sia_rx_fifo_pkg;

    localparam int SIA_SHIFT_REG_WIDTH = 16;

    localparam int RX_STAT_VALID_BIT   = 0;
    localparam int RX_STAT_FULL_BIT    = 1;
    localparam int RX_STAT_OVERRUN_BIT = 2;

endpackage

// File: rtl/sia_rx_fifo.sv
// First-word-fall-through receive queue behind the SIA serial receiver.
// A word is captured when the receiver's idle flag rises; overrun is sticky.
module sia_rx_fifo
    import sia_rx_fifo_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH = SIA_SHIFT_REG_WIDTH,
    parameter int DEPTH_LOG2      = 4,
    localparam int SRW            = SHIFT_REG_WIDTH - 1,
    localparam int DLW            = DEPTH_LOG2 - 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [SRW:0]      rx_dat_i,
    input  logic              rx_idle_i,
    input  logic              pop_i,
    input  logic              clr_ovr_i,
    output logic [SRW:0]      dat_o,
    output logic              valid_o,
    output logic              full_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic              overrun_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [SRW:0]        mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                idle_q;
    logic                ovr_q, ovr_d;

    logic empty;
    logic full;
    logic push;
    logic pop_eff;
    logic push_ok;
    logic drop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DLW:0] == rd_ptr_q[DLW:0]) &&
                     (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign push    = rx_idle_i & ~idle_q;
    assign pop_eff = pop_i & ~empty;
    // A full queue still accepts the new word if the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_eff);
    assign drop    = push & full & ~pop_eff;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idle_q   <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idle_q   <= rx_idle_i;
            ovr_q    <= ovr_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto LUT RAM.
    always_ff @(posedge clk_i) begin
        if (push_ok && !reset_i) begin
            mem_q[wr_ptr_q[DLW:0]] <= rx_dat_i;
        end
    end

    assign dat_o     = mem_q[rd_ptr_q[DLW:0]];
    assign valid_o   = ~empty;
    assign full_o    = full;
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign overrun_o = ovr_q;

endmodule
